// File: rtl/add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | add_sequencer: multi-word add/subtract through a shared 16-bit adder.      |
// | Optional: ADD_SEQUENCER_SAT_EN saturates on signed overflow. Rev 1.0       |
// +----------------------------------------------------------------------------+
module add_sequencer #(
  parameter int MAX_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [1:0]             nwords,
  input  logic [16*MAX_WORDS-1:0] opa,
  input  logic [16*MAX_WORDS-1:0] opb,
  output logic                   ready,
  output logic                   done,
  output logic [16*MAX_WORDS-1:0] result,
  output logic                   carry_out,
  output logic                   overflow,
  output logic [15:0]            add_a,
  output logic [15:0]            add_b,
  output logic                   add_cin,
  input  logic [15:0]            add_sum,
  input  logic                   add_cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [16*MAX_WORDS-1:0] opa_lat;
  logic [16*MAX_WORDS-1:0] opb_lat;
  logic                   sub_lat;
  logic [1:0]             nw_lat;
  logic [1:0]             idx;
  logic                   carry;
  logic [15:0]            res_word [4];
  logic [15:0]            res_next [4];
  logic [15:0]            a_word   [4];
  logic [15:0]            b_word   [4];
  logic [1:0]             nw_clamp;
  logic                   last;
  logic                   ovf_now;

  // Operands are viewed as four words; words beyond MAX_WORDS read as zero.
  genvar w;
  for (w = 0; w < 4; w++) begin : g_words
    if (w < MAX_WORDS) begin : g_live
      assign a_word[w]           = opa_lat[16*w +: 16];
      assign b_word[w]           = opb_lat[16*w +: 16];
      assign result[16*w +: 16]  = res_word[w];
    end else begin : g_pad
      assign a_word[w] = 16'h0000;
      assign b_word[w] = 16'h0000;
    end
  end

  if (MAX_WORDS >= 4) begin : g_no_clamp
    assign nw_clamp = nwords;
  end else begin : g_clamp
    localparam logic [1:0] NW_MAX = 2'(MAX_WORDS - 1);
    assign nw_clamp = (nwords > NW_MAX) ? NW_MAX : nwords;
  end

  assign last    = (idx == nw_lat);
  assign ovf_now = (add_a[15] == add_b[15]) && (add_sum[15] != add_a[15]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last)  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: adder is driven only while running
  always_comb begin
    ready   = (state == S_IDLE);
    done    = (state == S_DONE);
    add_a   = 16'h0000;
    add_b   = 16'h0000;
    add_cin = 1'b0;
    if (state == S_RUN) begin
      add_a   = a_word[idx];
      add_b   = sub_lat ? ~b_word[idx] : b_word[idx];
      add_cin = carry;
    end
  end

`ifdef ADD_SEQUENCER_SAT_EN
  logic sat_neg;
  assign sat_neg = a_word[nw_lat][15];
`endif

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      res_next[k] = (2'(k) == idx) ? add_sum : res_word[k];
    end
`ifdef ADD_SEQUENCER_SAT_EN
    // Saturation spans only the active words; the top active word carries the sign.
    if (last && ovf_now) begin
      for (int k = 0; k < 4; k++) begin
        if (2'(k) < nw_lat) begin
          res_next[k] = sat_neg ? 16'h0000 : 16'hFFFF;
        end else if (2'(k) == nw_lat) begin
          res_next[k] = sat_neg ? 16'h8000 : 16'h7FFF;
        end else begin
          res_next[k] = 16'h0000;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_lat   <= '0;
      opb_lat   <= '0;
      sub_lat   <= 1'b0;
      nw_lat    <= 2'd0;
      idx       <= 2'd0;
      carry     <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        res_word[k] <= 16'h0000;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            opa_lat   <= opa;
            opb_lat   <= opb;
            sub_lat   <= op_sub;
            nw_lat    <= nw_clamp;
            idx       <= 2'd0;
            carry     <= op_sub;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
              res_word[k] <= 16'h0000;
            end
          end
        end
        S_RUN: begin
          for (int k = 0; k < 4; k++) begin
            res_word[k] <= res_next[k];
          end
          carry <= add_cout;
          idx   <= last ? 2'd0 : idx + 2'd1;
          if (last) begin
            carry_out <= add_cout;
            overflow  <= ovf_now;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_add_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_add_sequencer: directed self-checking bench with arithmetic model.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_add_sequencer;

  localparam int MW = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          op_sub;
  logic [1:0]    nwords;
  logic [16*MW-1:0] opa;
  logic [16*MW-1:0] opb;
  logic          ready;
  logic          done;
  logic [16*MW-1:0] result;
  logic          carry_out;
  logic          overflow;
  logic [15:0]   add_a;
  logic [15:0]   add_b;
  logic          add_cin;
  logic [15:0]   add_sum;
  logic          add_cout;

  int n_checks = 0;
  int n_fail   = 0;

  add_sequencer #(.MAX_WORDS(MW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_sub    (op_sub),
    .nwords    (nwords),
    .opa       (opa),
    .opb       (opb),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // The shared external adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Whole-operand arithmetic over the active width; returns {carry, overflow, result}.
  function automatic logic [65:0] model_op(input int n, input logic sub,
                                           input logic [63:0] a, input logic [63:0] b);
    int          bits;
    logic [64:0] mask;
    logic [64:0] av;
    logic [64:0] bx;
    logic [64:0] full;
    logic [63:0] r;
    logic        c;
    logic        o;
    bits = 16 * (n + 1);
    mask = (65'd1 << bits) - 65'd1;
    av   = {1'b0, a} & mask;
    bx   = {1'b0, b} & mask;
    if (sub) bx = ~bx & mask;
    full = av + bx + (sub ? 65'd1 : 65'd0);
    r    = full[63:0] & mask[63:0];
    c    = full[bits];
    o    = (av[bits-1] == bx[bits-1]) && (full[bits-1] != av[bits-1]);
`ifdef ADD_SEQUENCER_SAT_EN
    if (o) r = av[bits-1] ? (64'd1 << (bits - 1)) : (mask[63:0] >> 1);
`endif
    return {c, o, r};
  endfunction

  // Model: remaining cycles until idle, plus the values the finished op must show.
  int          rem;
  logic [63:0] held_r;
  logic        held_c;
  logic        held_o;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    <= 0;
      held_r <= 64'd0;
      held_c <= 1'b0;
      held_o <= 1'b0;
    end else if (rem != 0) begin
      rem <= rem - 1;
    end else if (start) begin
      int nc;
      nc = (int'(nwords) > MW - 1) ? MW - 1 : int'(nwords);
      {held_c, held_o, held_r} <= model_op(nc, op_sub, opa, opb);
      rem <= nc + 2;
    end
  end

  always @(negedge clk) begin
    chk("ready", {63'd0, ready}, {63'd0, rem == 0});
    chk("done",  {63'd0, done},  {63'd0, rem == 1});
    if (rem <= 1) begin
      chk("result",    result, held_r);
      chk("carry_out", {63'd0, carry_out}, {63'd0, held_c});
      chk("overflow",  {63'd0, overflow},  {63'd0, held_o});
      chk("adder_idle", {31'd0, add_a, add_b, add_cin}, 64'd0);
    end
  end

  task automatic run_op(input string name, input logic [1:0] n, input logic sub,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] er, input logic ec, input logic eo,
                        input int elat, input bit noise);
    int cyc;
    bit seen;
    @(negedge clk);
    nwords = n; op_sub = sub; opa = a; opb = b; start = 1'b1;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (noise && cyc == 1) begin
        start = 1'b1; op_sub = ~sub; nwords = 2'd3;
        opa = 64'hFFFF_FFFF_FFFF_FFFF; opb = 64'h1234_5678_9ABC_DEF0;
      end else begin
        start = 1'b0;
      end
      if (done) seen = 1;
    end
    chk({name, "_done_seen"}, {63'd0, seen}, 64'd1);
    chk({name, "_latency"}, 64'(cyc), 64'(elat));
    chk({name, "_result"}, result, er);
    chk({name, "_carry"}, {63'd0, carry_out}, {63'd0, ec});
    chk({name, "_ovf"}, {63'd0, overflow}, {63'd0, eo});
  endtask

  initial begin
    bit saw_done;
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; nwords = 2'd0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready",  {63'd0, ready}, 64'd1);
    chk("reset_result", result, 64'd0);
    rst_n = 1'b1;

    run_op("add1w_carry", 2'd0, 1'b0, 64'h0001, 64'hFFFF, 64'h0, 1'b1, 1'b0, 2, 0);
    run_op("add4w_ripple", 2'd3, 1'b0, 64'hFFFF, 64'h1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 5, 0);
    run_op("sub2w_borrow", 2'd1, 1'b1, 64'h0, 64'h1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 3, 0);
`ifdef ADD_SEQUENCER_SAT_EN
    run_op("add1w_ovf", 2'd0, 1'b0, 64'h7FFF, 64'h0001, 64'h7FFF, 1'b0, 1'b1, 2, 0);
    run_op("add3w_negovf", 2'd2, 1'b0, 64'hABCD_8000_0000_0000, 64'h0000_8000_0000_0000,
           64'h0000_8000_0000_0000, 1'b1, 1'b1, 4, 0);
    run_op("sub4w_ovf", 2'd3, 1'b1, 64'h8000_0000_0000_0000, 64'h1,
           64'h8000_0000_0000_0000, 1'b1, 1'b1, 5, 0);
`else
    run_op("add1w_ovf", 2'd0, 1'b0, 64'h7FFF, 64'h0001, 64'h8000, 1'b0, 1'b1, 2, 0);
    run_op("add3w_negovf", 2'd2, 1'b0, 64'hABCD_8000_0000_0000, 64'h0000_8000_0000_0000,
           64'h0, 1'b1, 1'b1, 4, 0);
    run_op("sub4w_ovf", 2'd3, 1'b1, 64'h8000_0000_0000_0000, 64'h1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 5, 0);
`endif
    run_op("sub2w_upper_junk", 2'd1, 1'b1, 64'h0000_0000_0001_0000, 64'h1234_5678_0000_0001,
           64'h0000_0000_0000_FFFF, 1'b1, 1'b0, 3, 0);
    run_op("start_in_run", 2'd1, 1'b0, 64'h0001_0002, 64'h0003_0004,
           64'h0000_0000_0004_0006, 1'b0, 1'b0, 3, 1);

    // Reset during the second RUN cycle of a 4-word add
    @(negedge clk);
    nwords = 2'd3; op_sub = 1'b0; opa = 64'h1111_2222_3333_4444; opb = 64'h1; start = 1'b1;
    @(negedge clk);
    opa = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("midrun_reset_ready",  {63'd0, ready}, 64'd1);
    chk("midrun_reset_result", result, 64'd0);
    chk("midrun_reset_flags",  {62'd0, carry_out, overflow}, 64'd0);
    saw_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    chk("midrun_reset_no_done", {63'd0, saw_done}, 64'd0);

    run_op("sub1w_zero", 2'd0, 1'b1, 64'h5, 64'h5, 64'h0, 1'b1, 1'b0, 2, 0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
